// File: rtl/jtkcpu_busrsp.sv
// jtkcpu_busrsp: target-side responder for the KCPU memory bus.
// Decodes one RAM window of 2^AW bytes and inserts WAIT wait states before
// dtack. Accesses outside the window are acknowledged anyway: reads return
// OPENBUS, writes are dropped, and err pulses for one clk.
module jtkcpu_busrsp #(
  parameter int          AW      = 11,
  parameter logic [23:0] BASE    = 24'h0,
  parameter int          WAIT    = 1,
  parameter logic [7:0]  OPENBUS = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        as,
  input  logic [23:0] addr,
  input  logic        we,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        dtack,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ACK
  } state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  // Registered bus state
  state_t          state_q,   state_d;
  logic [3:0]      cnt_q,     cnt_d;
  logic [AW-1:0]   addr_q,    addr_d;
  logic            we_q,      we_d;
  logic [7:0]      wdata_q,   wdata_d;
  logic            hit_q,     hit_d;
  logic            dtack_q,   dtack_d;
  logic            err_q,     err_d;
  logic [7:0]      rdata_q,   rdata_d;
  logic            src_ram_q, src_ram_d;

  // RAM side
  logic [7:0]      mem [0:(1<<AW)-1];
  logic [7:0]      ram_dout_q;
  logic            ram_we;
  logic            ram_re;
  logic            hit_w;

  // Window decode: only the bits above the RAM address take part.
  assign hit_w = (addr[23:AW] == BASE[23:AW]);

  // Next-state logic for the bus cycle; RAM strobes fire only in DATA on cen.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hit_d     = hit_q;
    dtack_d   = dtack_q;
    rdata_d   = rdata_q;
    src_ram_d = src_ram_q;
    err_d     = 1'b0;   // err lasts one clk whatever cen does
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cen && as) begin
          // Address, direction, data and decode are frozen for the whole cycle.
          addr_d  = addr[AW-1:0];
          we_d    = we;
          wdata_d = wdata;
          hit_d   = hit_w;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT > 0) ? ST_WAIT : ST_DATA;
        end
      end

      ST_WAIT: begin
        if (cen) begin
          if (!as) begin
            state_d = ST_IDLE;          // CPU abandoned the cycle
          end else if (cnt_q <= 4'd1) begin
            state_d = ST_DATA;
          end else begin
            cnt_d   = cnt_q - 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (cen) begin
          if (!as) begin
            state_d = ST_IDLE;          // late abort: nothing is written
          end else begin
            dtack_d = 1'b1;
            state_d = ST_ACK;
            if (hit_q) begin
              if (we_q) begin
                ram_we = 1'b1;
              end else begin
                ram_re    = 1'b1;
                src_ram_d = 1'b1;
              end
            end else begin
              err_d = 1'b1;
              if (!we_q) begin
                src_ram_d = 1'b0;
                rdata_d   = OPENBUS;
              end
            end
          end
        end
      end

      ST_ACK: begin
        // Hold dtack and rdata until the CPU releases the strobe.
        if (cen && !as) begin
          dtack_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      hit_q     <= 1'b0;
      dtack_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      src_ram_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      hit_q     <= hit_d;
      dtack_q   <= dtack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      src_ram_q <= src_ram_d;
    end
  end

  // Single-port RAM: synchronous write, registered read, never both at once.
  always_ff @(posedge clk) begin
    // NOTE: the array and its read register have no reset; contents survive
    // rst_n and the array stays mappable onto block RAM.
    if (ram_we) begin
      mem[addr_q] <= wdata_q;
    end
    if (ram_re) begin
      ram_dout_q <= mem[addr_q];
    end
  end

  // Read data comes from the RAM register after a hit read, otherwise from
  // the local register (reset value or open-bus byte).
  assign rdata = src_ram_q ? ram_dout_q : rdata_q;
  assign dtack = dtack_q;
  assign err   = err_q;

endmodule

// File: tb/tb_jtkcpu_busrsp.sv
// Testbench for jtkcpu_busrsp: three instances with WAIT = 0, 1 and 3 share
// clk, cen and rst_n. A behavioural model (byte array per instance plus the
// last read value) predicts rdata, dtack latency and err for each cycle.
module tb_jtkcpu_busrsp;

  localparam int          N    = 3;
  localparam int          AW   = 11;
  localparam logic [7:0]  OPEN = 8'hFF;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cen   = 1'b0;
  logic        as_v    [N];
  logic [23:0] addr_v  [N];
  logic        we_v    [N];
  logic [7:0]  wdata_v [N];
  logic [7:0]  rdata_v [N];
  logic        dtack_v [N];
  logic        err_v   [N];

  // Reference model
  logic [7:0]  ref_mem   [N][2048];
  bit          ref_valid [N][2048];
  logic [7:0]  ref_rdata [N];

  int n_total = 0;
  int n_bad   = 0;
  int cen_mode = 2;   // 0: random, 1: every other clk, 2: always

  jtkcpu_busrsp #(.AW(AW), .BASE(24'h0), .WAIT(0), .OPENBUS(OPEN)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .as(as_v[0]), .addr(addr_v[0]),
    .we(we_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]), .dtack(dtack_v[0]),
    .err(err_v[0]));
  jtkcpu_busrsp #(.AW(AW), .BASE(24'h0), .WAIT(1), .OPENBUS(OPEN)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .as(as_v[1]), .addr(addr_v[1]),
    .we(we_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]), .dtack(dtack_v[1]),
    .err(err_v[1]));
  jtkcpu_busrsp #(.AW(AW), .BASE(24'h0), .WAIT(3), .OPENBUS(OPEN)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .as(as_v[2]), .addr(addr_v[2]),
    .we(we_v[2]), .wdata(wdata_v[2]), .rdata(rdata_v[2]), .dtack(dtack_v[2]),
    .err(err_v[2]));

  always #5 clk = ~clk;

  // Clock-enable pattern, changed only on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      case (cen_mode)
        0:       cen = ($urandom_range(0, 2) != 0);
        1:       cen = ~cen;
        default: cen = 1'b1;
      endcase
    end
  end

  function automatic int wait_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next clk edge that has cen=1.
  task automatic next_tick(output bit ok);
    logic c;
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      c = cen;
      #1;
      if (c) begin
        ok = 1'b1;
        return;
      end
    end
    n_total++;
    n_bad++;
    $display("FAIL tick_timeout: no cen within 64 clk at %0t", $time);
  endtask

  // After the latch the bus lines carry junk; the DUT must ignore it.
  task automatic scramble(input int i);
    addr_v[i]  = 24'($urandom);
    we_v[i]    = 1'($urandom);
    wdata_v[i] = 8'($urandom);
  endtask

  // One complete bus cycle, holding as for 'hold' extra ticks after dtack.
  task automatic bus_cycle(input int i, input logic [23:0] a, input logic w,
                           input logic [7:0] d, input int hold);
    logic       hit;
    logic [7:0] exp_rd;
    int         ticks;
    bit         ok;
    bit         seen;
    hit = (a[23:AW] == '0);
    @(negedge clk);
    as_v[i] = 1'b1; addr_v[i] = a; we_v[i] = w; wdata_v[i] = d;
    ticks = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      next_tick(ok);
      if (!ok) break;
      ticks++;
      scramble(i);
      if (dtack_v[i]) seen = 1'b1;
    end
    // Ticks counted include the one that samples as in IDLE.
    check($sformatf("dtack_latency[%0d]", i), seen ? ticks : 999, wait_of(i) + 2);
    if (!seen) begin
      @(negedge clk);
      as_v[i] = 1'b0;
      return;
    end
    check($sformatf("err_on_ack[%0d]", i), err_v[i], !hit);
    if (w) begin
      exp_rd = ref_rdata[i];
      if (hit) begin
        ref_mem[i][a[AW-1:0]]   = d;
        ref_valid[i][a[AW-1:0]] = 1'b1;
      end
    end else begin
      exp_rd = hit ? ref_mem[i][a[AW-1:0]] : OPEN;
      ref_rdata[i] = exp_rd;
    end
    check($sformatf("rdata[%0d]", i), rdata_v[i], exp_rd);
    @(posedge clk);
    #1;
    check($sformatf("err_one_clk[%0d]", i), err_v[i], 1'b0);
    check($sformatf("dtack_held[%0d]", i), dtack_v[i], 1'b1);
    for (int k = 0; k < hold; k++) begin
      next_tick(ok);
      scramble(i);
      check($sformatf("dtack_hold[%0d]", i), dtack_v[i], 1'b1);
      check($sformatf("rdata_hold[%0d]", i), rdata_v[i], exp_rd);
    end
    @(negedge clk);
    as_v[i] = 1'b0;
    next_tick(ok);
    check($sformatf("dtack_fall[%0d]", i), dtack_v[i], 1'b0);
    check($sformatf("rdata_keep[%0d]", i), rdata_v[i], exp_rd);
  endtask

  // Write cycle abandoned right after the sampling tick: no dtack, no write.
  task automatic abort_cycle(input int i, input logic [23:0] a, input logic [7:0] d);
    bit ok;
    @(negedge clk);
    as_v[i] = 1'b1; addr_v[i] = a; we_v[i] = 1'b1; wdata_v[i] = d;
    next_tick(ok);
    @(negedge clk);
    as_v[i] = 1'b0;
    for (int k = 0; k < wait_of(i) + 3; k++) begin
      next_tick(ok);
      check($sformatf("abort_dtack[%0d]", i), dtack_v[i], 1'b0);
      check($sformatf("abort_err[%0d]", i), err_v[i], 1'b0);
    end
  endtask

  task automatic read_back(input int i, input logic [AW-1:0] lo);
    bus_cycle(i, {{(24-AW){1'b0}}, lo}, 1'b0, 8'h00, 0);
  endtask

  initial begin
    bit          ok;
    int          i;
    int          op;
    int          hold;
    logic [AW-1:0] lo;
    logic [23:0] a;

    for (int k = 0; k < N; k++) begin
      as_v[k] = 1'b0; addr_v[k] = '0; we_v[k] = 1'b0; wdata_v[k] = '0;
      ref_rdata[k] = 8'h00;
    end

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_dtack[%0d]", k), dtack_v[k], 1'b0);
      check($sformatf("rst_err[%0d]", k),   err_v[k],   1'b0);
      check($sformatf("rst_rdata[%0d]", k), rdata_v[k], 8'h00);
    end
    rst_n = 1'b1;
    cen_mode = 2;

    // Write then read back in the window, WAIT=1
    bus_cycle(1, 24'h000003, 1'b1, 8'h5A, 0);
    read_back(1, 11'd3);

    // Unmapped read returns open bus; unmapped write does not alias into RAM
    bus_cycle(1, 24'h000803, 1'b0, 8'h00, 0);
    bus_cycle(1, 24'h400003, 1'b1, 8'hA5, 1);
    read_back(1, 11'd3);

    // Abort during WAIT leaves RAM untouched, for every wait setting
    for (int k = 0; k < N; k++) begin
      bus_cycle(k, 24'h000000, 1'b1, 8'h11, 0);
      abort_cycle(k, 24'h000000, 8'h77);
      read_back(k, 11'd0);
    end

    // WAIT=0 with cen every other clk
    cen_mode = 1;
    for (int k = 0; k < 16; k++) bus_cycle(0, 24'(k), 1'b1, 8'(k), 0);
    for (int k = 0; k < 16; k++) read_back(0, 11'(k));

    // Long hold after dtack: no retrigger, no second write
    cen_mode = 0;
    bus_cycle(1, 24'h000007, 1'b1, 8'h3C, 10);
    bus_cycle(2, 24'h000007, 1'b0, 8'h00, 10);
    read_back(1, 11'd7);

    // Reset while in WAIT: dtack low at once, the older write survives
    cen_mode = 2;
    bus_cycle(2, 24'h000005, 1'b1, 8'hC3, 0);
    @(negedge clk);
    as_v[2] = 1'b1; addr_v[2] = 24'h000005; we_v[2] = 1'b1; wdata_v[2] = 8'h3C;
    next_tick(ok);
    next_tick(ok);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wait_dtack", dtack_v[2], 1'b0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_mid_rdata[%0d]", k), rdata_v[k], 8'h00);
      ref_rdata[k] = 8'h00;
    end
    @(negedge clk);
    as_v[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_back(2, 11'd5);

    // Reset while dtack is high: the completed write counts
    @(negedge clk);
    as_v[1] = 1'b1; addr_v[1] = 24'h000009; we_v[1] = 1'b1; wdata_v[1] = 8'h66;
    for (int k = 0; k < 20 && !dtack_v[1]; k++) next_tick(ok);
    check("pre_rst_dtack", dtack_v[1], 1'b1);
    ref_mem[1][9] = 8'h66;
    ref_valid[1][9] = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ack_dtack", dtack_v[1], 1'b0);
    for (int k = 0; k < N; k++) ref_rdata[k] = 8'h00;
    @(negedge clk);
    as_v[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    read_back(1, 11'd9);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      i        = $urandom_range(0, N - 1);
      cen_mode = $urandom_range(0, 2);
      op       = $urandom_range(0, 4);
      lo       = AW'($urandom_range(0, 63));
      hold     = $urandom_range(0, 3);
      case (op)
        0: bus_cycle(i, {{(24-AW){1'b0}}, lo}, 1'b1, 8'($urandom), hold);
        1: begin
          if (ref_valid[i][lo]) bus_cycle(i, {{(24-AW){1'b0}}, lo}, 1'b0, 8'h00, hold);
          else                  bus_cycle(i, {{(24-AW){1'b0}}, lo}, 1'b1, 8'($urandom), hold);
        end
        2, 3: begin
          a = {13'($urandom_range(1, 8191)), lo};
          bus_cycle(i, a, 1'($urandom), 8'($urandom), hold);
        end
        default: abort_cycle(i, {{(24-AW){1'b0}}, lo}, 8'($urandom));
      endcase
    end

    // Final sweep: every location the model knows must match
    cen_mode = 2;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < 64; m++) begin
        if (ref_valid[k][m]) read_back(k, 11'(m));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
